// File: rtl/booth_mult_pkg.sv
// Shared parameters and state encoding for the radix-4 Booth multiplier blocks.
// booth2_pp_gen, the Wallace tree and booth2_pp_accum all size their datapaths from here.
package booth_mult_pkg;

  localparam int A_W    = 16;
  localparam int PP_W   = A_W + 2;
  localparam int NUM_PP = A_W / 2;
  localparam int P_W    = 2 * A_W;
  // Kept at least 1 bit wide so the NUM_PP==1 build still has a legal counter.
  localparam int CNT_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Radix-4 digit idx carries weight 4^idx, i.e. a left shift of 2*idx.
  function automatic logic [CNT_W:0] pp_shift(input logic [CNT_W-1:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/booth2_pp_align.sv
// Sign-extends one Booth partial product to product width and weights it by 4^idx.
// Purely combinational; also used as the input stage of the Wallace reduction.
module booth2_pp_align
  import booth_mult_pkg::*;
(
  input  logic [PP_W-1:0]  pp,
  input  logic [CNT_W-1:0] idx,
  output logic [P_W-1:0]   aligned
);

  logic [P_W-1:0] pp_sext;

  assign pp_sext = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
  assign aligned = pp_sext << pp_shift(idx);

endmodule

// File: rtl/booth2_pp_accum.sv
// Sequential sink for the Booth partial-product stream: accumulates NUM_PP weighted
// partial products and hands the signed product downstream on a valid/ready port.
module booth2_pp_accum
  import booth_mult_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            PP_VALID,
  output logic            PP_READY,
  input  logic [PP_W-1:0] PP_DATA,
  input  logic            FLUSH,
  output logic            P_VALID,
  input  logic            P_READY,
  output logic [P_W-1:0]  P_DATA,
  output logic            BUSY
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   pp_aligned;
  logic [P_W-1:0]   sum;
  logic             ready_en;
  logic             flush_ok;
  logic             beat;
  logic             last_beat;

  // ready_en holds PP_READY low during reset and until the first edge after release.
  assign PP_READY  = ready_en && (state != HOLD);
  assign BUSY      = (state != IDLE);
  assign flush_ok  = FLUSH && (state != HOLD);
  assign beat      = PP_VALID && PP_READY && !flush_ok;
  assign last_beat = beat && (cnt == CNT_W'(NUM_PP - 1));

  booth2_pp_align u_align (
    .pp      (PP_DATA),
    .idx     (cnt),
    .aligned (pp_aligned)
  );

  // In IDLE the first PP replaces whatever acc holds, so the base is zero.
  assign sum = ((state == ACC) ? acc : '0) + pp_aligned;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (beat) begin
          state_next = last_beat ? HOLD : ACC;
        end
      end
      ACC: begin
        if (flush_ok) begin
          state_next = IDLE;
        end else if (last_beat) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (P_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ready_en <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      P_VALID  <= 1'b0;
      P_DATA   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush_ok) begin
        acc <= '0;
        cnt <= '0;
      end else if (last_beat) begin
        acc     <= sum;
        cnt     <= '0;
        P_DATA  <= sum;
        P_VALID <= 1'b1;
      end else if (beat) begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == HOLD) && P_READY) begin
        P_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth2_pp_accum.sv
// Self-checking bench for booth2_pp_accum: Booth-recoded PP streams are built here from
// A and B, and every product is compared with plain signed multiplication.
module tb_booth2_pp_accum;
  import booth_mult_pkg::*;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            PP_VALID  = 1'b0;
  logic [PP_W-1:0] PP_DATA   = '0;
  logic            FLUSH     = 1'b0;
  logic            P_READY   = 1'b0;
  logic            PP_READY;
  logic            P_VALID;
  logic [P_W-1:0]  P_DATA;
  logic            BUSY;

  int checks = 0;
  int passed = 0;
  int cycle  = 0;
  bit mon_en = 1'b0;
  int             mon_cyc[$];
  logic [P_W-1:0] mon_data[$];

  booth2_pp_accum dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .PP_VALID  (PP_VALID),
    .PP_READY  (PP_READY),
    .PP_DATA   (PP_DATA),
    .FLUSH     (FLUSH),
    .P_VALID   (P_VALID),
    .P_READY   (P_READY),
    .P_DATA    (P_DATA),
    .BUSY      (BUSY)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cycle <= cycle + 1;

  // Records every product handshake that will complete at the next rising edge.
  always @(negedge sys_clk) begin
    if (mon_en && P_VALID && P_READY) begin
      mon_cyc.push_back(cycle);
      mon_data.push_back(P_DATA);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Radix-4 Booth digit idx of A times B, as an 18-bit two's-complement value.
  function automatic logic [PP_W-1:0] pp_of(input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                                           input int idx);
    int d;
    int p;
    logic [31:0] pv;
    d = a[2*idx];
    if (a[2*idx+1]) d = d - 2;
    if (idx > 0) d = d + int'(a[2*idx-1]);
    p  = d * int'($signed(b));
    pv = p;
    return pv[PP_W-1:0];
  endfunction

  function automatic logic [P_W-1:0] prod_of(input logic [A_W-1:0] a, input logic [A_W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p;
  endfunction

  task automatic send_pp(input logic [PP_W-1:0] pp, input int gap);
    bit done;
    done = 1'b0;
    PP_VALID = 1'b1;
    PP_DATA  = pp;
    for (int k = 0; k < 50 && !done; k++) begin
      if (PP_READY) done = 1'b1;
      tick();
    end
    PP_VALID = 1'b0;
    if (!done) begin
      checks++;
      $display("[TB] FAIL pp_accept: PP_READY never seen, got 0 required 1");
    end
    repeat (gap) tick();
  endtask

  task automatic send_beats(input logic [A_W-1:0] a, input logic [A_W-1:0] b, input int n,
                            input int gap);
    for (int i = 0; i < n; i++) send_pp(pp_of(a, b, i), (i == n - 1) ? 0 : gap);
  endtask

  // Called right after the last beat; checks P_VALID latency, data, backpressure, transfer.
  task automatic finish_product(input string name, input logic [A_W-1:0] a,
                                input logic [A_W-1:0] b, input int hold);
    logic [P_W-1:0] exp;
    exp = prod_of(a, b);
    checks++;
    if (P_VALID !== 1'b1) $display("[TB] FAIL %s_valid: got %b required 1", name, P_VALID);
    else passed++;
    checks++;
    if (P_DATA !== exp) $display("[TB] FAIL %s_data: got %h required %h", name, P_DATA, exp);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      PP_VALID = 1'b1;
      PP_DATA  = '1;
      tick();
      checks++;
      if (P_VALID !== 1'b1 || P_DATA !== exp || PP_READY !== 1'b0)
        $display("[TB] FAIL %s_hold%0d: got valid=%b data=%h ppready=%b required 1 %h 0",
                 name, i, P_VALID, P_DATA, PP_READY, exp);
      else passed++;
    end
    PP_VALID = 1'b0;
    P_READY  = 1'b1;
    tick();
    P_READY  = 1'b0;
    checks++;
    if (P_VALID !== 1'b0 || BUSY !== 1'b0 || PP_READY !== 1'b1)
      $display("[TB] FAIL %s_xfer: got valid=%b busy=%b ppready=%b required 0 0 1",
               name, P_VALID, BUSY, PP_READY);
    else passed++;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (PP_READY !== 1'b0 || P_VALID !== 1'b0 || P_DATA !== '0 || BUSY !== 1'b0)
      $display("[TB] FAIL %s: got ppready=%b valid=%b data=%h busy=%b required 0 0 0 0",
               name, PP_READY, P_VALID, P_DATA, BUSY);
    else passed++;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset_values");
    sys_rst_n = 1'b1;
    #1;
    checks++;
    if (PP_READY !== 1'b0) $display("[TB] FAIL release_ready_early: got %b required 0", PP_READY);
    else passed++;
    tick();
    checks++;
    if (PP_READY !== 1'b1) $display("[TB] FAIL release_ready: got %b required 1", PP_READY);
    else passed++;
    P_READY = 1'b1;
    repeat (2) tick();
    P_READY = 1'b0;
    checks++;
    if (P_VALID !== 1'b0 || BUSY !== 1'b0)
      $display("[TB] FAIL idle_p_ready: got valid=%b busy=%b required 0 0", P_VALID, BUSY);
    else passed++;
  endtask

  task automatic test_directed();
    send_beats(16'h8000, 16'h0019, NUM_PP, 0);
    finish_product("min_neg", 16'h8000, 16'h0019, 0);
    send_beats(16'h0001, 16'h0001, NUM_PP, 0);
    finish_product("one", 16'h0001, 16'h0001, 0);
    send_beats(16'h0009, 16'h0009, NUM_PP, 0);
    finish_product("nine", 16'h0009, 16'h0009, 0);
  endtask

  task automatic test_gaps();
    send_beats(16'h0009, 16'h0009, NUM_PP, 2);
    finish_product("nine_gaps", 16'h0009, 16'h0009, 0);
  endtask

  task automatic test_backpressure();
    send_beats(16'h0019, 16'h0019, NUM_PP, 0);
    finish_product("hold5", 16'h0019, 16'h0019, 5);
  endtask

  task automatic test_reset_mid();
    send_beats(16'h0009, 16'h0009, 4, 0);
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset_values");
    tick();
    sys_rst_n = 1'b1;
    tick();
    send_beats(16'h0001, 16'h0001, NUM_PP, 0);
    finish_product("after_reset", 16'h0001, 16'h0001, 0);
  endtask

  task automatic test_flush();
    send_beats(16'h0009, 16'h0009, 3, 0);
    FLUSH    = 1'b1;
    PP_VALID = 1'b1;
    PP_DATA  = 18'h2AAAA;
    tick();
    FLUSH    = 1'b0;
    PP_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || PP_READY !== 1'b1)
      $display("[TB] FAIL flush_idle: got busy=%b ppready=%b required 0 1", BUSY, PP_READY);
    else passed++;
    send_beats(16'h0001, 16'h0001, NUM_PP, 0);
    finish_product("after_flush", 16'h0001, 16'h0001, 0);
  endtask

  task automatic test_back_to_back();
    mon_cyc.delete();
    mon_data.delete();
    mon_en  = 1'b1;
    P_READY = 1'b1;
    send_beats(16'h0009, 16'h0009, NUM_PP, 0);
    send_beats(16'h0019, 16'h0019, NUM_PP, 0);
    repeat (4) tick();
    mon_en  = 1'b0;
    P_READY = 1'b0;
    checks++;
    if (mon_cyc.size() != 2)
      $display("[TB] FAIL b2b_count: got %0d required 2", mon_cyc.size());
    else begin
      passed++;
      checks++;
      if (mon_cyc[1] - mon_cyc[0] != NUM_PP + 1)
        $display("[TB] FAIL b2b_spacing: got %0d required %0d", mon_cyc[1] - mon_cyc[0], NUM_PP + 1);
      else passed++;
      checks++;
      if (mon_data[0] !== 32'h51 || mon_data[1] !== 32'h271)
        $display("[TB] FAIL b2b_data: got %h %h required 00000051 00000271", mon_data[0], mon_data[1]);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
    for (int n = 0; n < 16; n++) begin
      a = A_W'($urandom);
      b = A_W'($urandom);
      if (n == 0) a = 16'h8000;
      if (n == 1) b = 16'h8000;
      send_beats(a, b, NUM_PP, $urandom_range(0, 2));
      finish_product($sformatf("rand%0d", n), a, b, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
